conv_line_feeder: RTL and testbench

- Pixel source for the 3x3 convolution engine. Loads an image from a synchronous-read frame memory into three internal row buffers.
- Presents one 3-row column per `shift_buffer` request on `in_l1`/`in_l2`/`in_l3`.
- At the end of each row band, advances the band by the programmed stride. The band moves down 1 or 2 image rows and only the new rows are refetched.
- Responder end of the `shift_buffer`/`in_l*` interface, which the convolution engine drives.

---
 rtl/conv_line_feeder.sv | 197 +++++++++++++++++++
 tb/tb_conv_line_feeder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_feeder.sv
// Row-band pixel feeder for the 3x3 convolution engine.
// Image row r always lives in row buffer slot r % 3, so a band advance only overwrites
// the slots of departing rows and reads simply continue from the previous address.
module conv_line_feeder #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned IMG_W     = 16,
    parameter int unsigned IMG_H     = 16,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           stride,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [BIT_DEPTH-1:0] mem_rd_data,
    input  logic                 shift_buffer,
    output logic [BIT_DEPTH-1:0] in_l1,
    output logic [BIT_DEPTH-1:0] in_l2,
    output logic [BIT_DEPTH-1:0] in_l3,
    output logic                 col_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underflow
);
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned CNT_W = $clog2(3 * IMG_W + 1);
    localparam int unsigned TOP_W = $clog2(IMG_H) + 2;
    localparam logic [CNT_W-1:0] FILL_N   = CNT_W'(3 * IMG_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [TOP_W-1:0] ROW_LAST = TOP_W'(IMG_H - 1);

    typedef enum logic [2:0] {StIdle, StFill, StStream, StRefill, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [TOP_W-1:0]     top_q, top_d;
    logic [1:0]           slot_q, slot_d;
    logic                 stride_q;
    logic [ADDR_W-1:0]    rd_addr_q, last_addr_q;
    logic [1:0]           rd_slot_q, wr_slot_q;
    logic [COL_W-1:0]     rd_col_q, wr_col_q;
    logic                 wr_en_q, underflow_q;
    logic [BIT_DEPTH-1:0] row_buf [3][IMG_W];

    logic             start_ok, rd_en, band_fits;
    logic [1:0]       step_top;
    logic [CNT_W-1:0] refill_n;
    // Only stride[1] selects the step; the LSB carries no meaning.
    logic             unused_stride_lsb;

    function automatic logic [1:0] slot_add(input logic [1:0] slot, input logic [1:0] inc);
        logic [2:0] sum;
        sum = {1'b0, slot} + {1'b0, inc};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    assign unused_stride_lsb = stride[0];
    assign start_ok  = (state_q == StIdle) && start;
    assign step_top  = stride_q ? 2'd2 : 2'd1;
    assign refill_n  = stride_q ? CNT_W'(2 * IMG_W) : CNT_W'(IMG_W);
    assign band_fits = (top_q + TOP_W'(step_top) + TOP_W'(2)) <= ROW_LAST;
    assign rd_en     = ((state_q == StFill) && (cnt_q < FILL_N)) ||
                       ((state_q == StRefill) && (cnt_q < refill_n));

    assign mem_rd_en  = rd_en;
    assign mem_addr   = rd_en ? rd_addr_q : last_addr_q;
    assign col_valid  = (state_q == StStream);
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign underflow  = underflow_q;
    assign in_l1 = col_valid ? row_buf[slot_q][col_q] : '0;
    assign in_l2 = col_valid ? row_buf[slot_add(slot_q, 2'd1)][col_q] : '0;
    assign in_l3 = col_valid ? row_buf[slot_add(slot_q, 2'd2)][col_q] : '0;

    // State register and band/column pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            col_q   <= '0;
            top_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            top_q   <= top_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state logic: fill, stream columns, refill new rows, finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        top_d   = top_q;
        slot_d  = slot_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == FILL_N) begin
                    state_d = StStream;
                    cnt_d   = '0;
                    col_d   = '0;
                    top_d   = '0;
                    slot_d  = '0;
                end
            end
            StStream: begin
                if (shift_buffer) begin
                    if (col_q != COL_LAST) begin
                        col_d = col_q + COL_W'(1);
                    end else if (band_fits) begin
                        state_d = StRefill;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRefill: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == refill_n) begin
                    state_d = StStream;
                    cnt_d   = '0;
                    col_d   = '0;
                    top_d   = top_q + TOP_W'(step_top);
                    slot_d  = slot_add(slot_q, step_top);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latch frame settings on start; walk the read address, slot and column per read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q    <= 1'b0;
            rd_addr_q   <= '0;
            last_addr_q <= '0;
            rd_slot_q   <= '0;
            rd_col_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_slot_q   <= '0;
            wr_col_q    <= '0;
        end else begin
            wr_en_q   <= rd_en;
            wr_slot_q <= rd_slot_q;
            wr_col_q  <= rd_col_q;
            if (start_ok) begin
                stride_q  <= stride[1];
                rd_addr_q <= base_addr;
                rd_slot_q <= '0;
                rd_col_q  <= '0;
            end else if (rd_en) begin
                rd_addr_q   <= rd_addr_q + ADDR_W'(1);
                last_addr_q <= rd_addr_q;
                if (rd_col_q == COL_LAST) begin
                    rd_col_q  <= '0;
                    rd_slot_q <= slot_add(rd_slot_q, 2'd1);
                end else begin
                    rd_col_q <= rd_col_q + COL_W'(1);
                end
            end
        end
    end

    // Sticky underflow: consumer asked for a column when none was presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if (start_ok) begin
            underflow_q <= 1'b0;
        end else if (shift_buffer && !col_valid) begin
            underflow_q <= 1'b1;
        end
    end

    // Capture each returned word into the slot/column it was read for.
    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            row_buf[wr_slot_q][wr_col_q] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_conv_line_feeder.sv
// Bench for conv_line_feeder: frame memory model, per-frame expected column and read-address
// queues built from image arithmetic, a negedge compare process, and directed scenarios.
module tb_conv_line_feeder;
    localparam int BD = 8;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    stride = 2'b00;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [BD-1:0] mem_rd_data = '0;
    logic          shift_buffer = 1'b0;
    logic [BD-1:0] in_l1, in_l2, in_l3;
    logic          col_valid, busy, frame_done, underflow;

    int total = 0;
    int bad   = 0;

    logic [BD-1:0]   mem [256];
    logic [3*BD-1:0] colq [$];
    logic [AW-1:0]   addrq [$];
    int n_shift = 0;
    int n_bands = 0;
    int n_done  = 0;
    bit exp_uf  = 1'b0;
    bit prev_valid = 1'b0;

    conv_line_feeder #(
        .BIT_DEPTH(BD), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stride(stride), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .shift_buffer(shift_buffer), .in_l1(in_l1), .in_l2(in_l2), .in_l3(in_l3),
        .col_valid(col_valid), .busy(busy), .frame_done(frame_done), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame memory.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbands(input logic [1:0] st);
        return (H - 3) / (st[1] ? 2 : 1) + 1;
    endfunction

    function automatic logic [BD-1:0] px(input logic [AW-1:0] b, input int r, input int c);
        logic [AW-1:0] a;
        a = AW'(int'(b) + r * W + c);
        return mem[a];
    endfunction

    // Expected frame: every read address in order, and every band's columns in order.
    task automatic build_frame(input logic [AW-1:0] b, input logic [1:0] st);
        int s, nb;
        s  = st[1] ? 2 : 1;
        nb = nbands(st);
        colq.delete();
        addrq.delete();
        for (int a = 0; a < (3 + (nb - 1) * s) * W; a++) addrq.push_back(AW'(int'(b) + a));
        for (int k = 0; k < nb; k++)
            for (int c = 0; c < W; c++)
                colq.push_back({px(b, k * s, c), px(b, k * s + 1, c), px(b, k * s + 2, c)});
    endtask

    // Compare process: outputs sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                colq.delete();
                addrq.delete();
                exp_uf     = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    if (addrq.size() == 0) chk("unexpected_read", int'(mem_addr), -1);
                    else chk("mem_addr", int'(mem_addr), int'(addrq.pop_front()));
                end
                if (col_valid) begin
                    if (colq.size() == 0) begin
                        chk("unexpected_column", 1, 0);
                    end else begin
                        chk("in_l1", int'(in_l1), int'(colq[0][3*BD-1:2*BD]));
                        chk("in_l2", int'(in_l2), int'(colq[0][2*BD-1:BD]));
                        chk("in_l3", int'(in_l3), int'(colq[0][BD-1:0]));
                        if (shift_buffer) begin
                            void'(colq.pop_front());
                            n_shift++;
                        end
                    end
                    if (!prev_valid) n_bands++;
                end else begin
                    chk("in_l_zero", int'({in_l1, in_l2, in_l3}), 0);
                end
                chk("underflow", int'(underflow), int'(exp_uf));
                if (frame_done) begin
                    n_done++;
                    chk("cols_left_at_done", colq.size(), 0);
                    chk("reads_left_at_done", addrq.size(), 0);
                end
                if (start && !busy) begin
                    build_frame(base_addr, stride);
                    exp_uf  = 1'b0;
                    n_shift = 0;
                    n_bands = 0;
                    n_done  = 0;
                end else if (shift_buffer && !col_valid) begin
                    exp_uf = 1'b1;
                end
                prev_valid = col_valid;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [1:0] st);
        base_addr = b;
        stride    = st;
        start     = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!col_valid && n < 500) begin
            step();
            n++;
        end
    endtask

    // Accept n columns, optionally with random back-pressure.
    task automatic consume(input int n, input bit rnd);
        int got = 0;
        int g   = 0;
        while (got < n && g < 5000) begin
            if (col_valid && (!rnd || $urandom_range(0, 1) == 1)) begin
                shift_buffer = 1'b1;
                got++;
            end else begin
                shift_buffer = 1'b0;
            end
            step();
            g++;
        end
        shift_buffer = 1'b0;
        chk("consumed", got, n);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!frame_done && g < 2000) begin
            step();
            g++;
        end
        chk("frame_done_seen", int'(frame_done), 1);
        chk("busy_at_done", int'(busy), 1);
        step();
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic frame_counts(input logic [1:0] st);
        chk("shift_count", n_shift, nbands(st) * W);
        chk("band_count", n_bands, nbands(st));
        chk("done_count", n_done, 1);
    endtask

    initial begin
        int n;
        logic [AW-1:0] b;
        logic [1:0] st;
        for (int a = 0; a < 256; a++) mem[a] = BD'(a);
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_col_valid", int'(col_valid), 0);
        chk("rst_rd_en", int'(mem_rd_en), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_in", int'({in_l1, in_l2, in_l3}), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_underflow", int'(underflow), 0);
        rst = 1'b0;
        step();

        // Stride 1 from address 0, with fixed and literal expectations.
        do_start(8'd0, 2'b00);
        wait_valid(n);
        chk("fill_latency", n, 49);
        chk("b0_l1", int'(in_l1), 0);
        chk("b0_l2", int'(in_l2), 16);
        chk("b0_l3", int'(in_l3), 32);
        shift_buffer = 1'b1;
        for (int c = 0; c < W; c++) begin
            chk("stream_l1", int'(in_l1), c);
            chk("stream_l3", int'(in_l3), 32 + c);
            step();
        end
        shift_buffer = 1'b0;
        wait_valid(n);
        chk("refill1_gap", n, 17);
        chk("b1_l1", int'(in_l1), 16);
        chk("b1_l2", int'(in_l2), 32);
        chk("b1_l3", int'(in_l3), 48);
        consume(14 * W - W, 1'b1);
        wait_done();
        frame_counts(2'b00);

        // Stride 2 from address 8.
        do_start(8'd8, 2'b10);
        wait_valid(n);
        chk("fill_latency_s2", n, 49);
        consume(W, 1'b1);
        wait_valid(n);
        chk("refill2_gap", n, 33);
        chk("s2_l1", int'(in_l1), 40);
        chk("s2_l2", int'(in_l2), 56);
        chk("s2_l3", int'(in_l3), 72);
        consume(6 * W, 1'b1);
        wait_done();
        frame_counts(2'b10);

        // Random images, bases and strides under random back-pressure.
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 256; a++) mem[a] = BD'($urandom);
            b  = AW'($urandom);
            st = 2'($urandom);
            do_start(b, st);
            wait_valid(n);
            chk("fill_latency_rnd", n, 49);
            consume(nbands(st) * W, 1'b1);
            wait_done();
            frame_counts(st);
        end

        // Underflow during fill, ignored start while streaming.
        for (int a = 0; a < 256; a++) mem[a] = BD'(a);
        do_start(8'd0, 2'b00);
        shift_buffer = 1'b1;
        repeat (3) step();
        shift_buffer = 1'b0;
        chk("uf_set", int'(underflow), 1);
        wait_valid(n);
        chk("uf_col0", int'(in_l1), 0);
        chk("uf_sticky", int'(underflow), 1);
        do_start(8'd100, 2'b10);
        chk("ign_start_valid", int'(col_valid), 1);
        chk("ign_start_l2", int'(in_l2), 16);
        consume(14 * W, 1'b1);
        wait_done();
        frame_counts(2'b00);
        chk("uf_after_frame", int'(underflow), 1);
        do_start(8'd0, 2'b00);
        chk("uf_cleared", int'(underflow), 0);

        // Reset in the middle of a refill.
        wait_valid(n);
        consume(W, 1'b0);
        repeat (3) step();
        chk("in_refill", int'(mem_rd_en), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_rd_en", int'(mem_rd_en), 0);
        chk("arst_addr", int'(mem_addr), 0);
        chk("arst_col_valid", int'(col_valid), 0);
        chk("arst_in", int'({in_l1, in_l2, in_l3}), 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("abort_no_done", n_done, 0);
        do_start(8'd0, 2'b00);
        wait_valid(n);
        chk("fill_after_rst", n, 49);
        chk("rst_b0_l1", int'(in_l1), 0);
        chk("rst_b0_l3", int'(in_l3), 32);
        consume(14 * W, 1'b1);
        wait_done();
        frame_counts(2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
